// File: rtl/fwft_fifo_to_standard_fifo_pkg.sv
// Shared FIFO adapter definitions: latency bound and delay-line flag record.
// Used by both the FWFT-to-standard and standard-to-FWFT converters.
package fifo_pkg;

   localparam int FIFO_READ_LATENCY_MAX = 8;

   typedef struct packed {
      logic accept;
      logic reject;
   } stage_flags_t;

   function automatic int cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction

   function automatic bit lat_legal(input int lat);
      return (lat >= 1) && (lat <= FIFO_READ_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/fwft_fifo_to_standard_fifo_if.sv
// Read-side bundle: FWFT FIFO port on one side, standard-FIFO consumer
// port on the other.
interface fwft_fifo_to_standard_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 2
);

   localparam int CNT_W = cnt_width(READ_LATENCY);

   logic [DATA_WIDTH-1:0] fwft_dout;
   logic                  fwft_empty;
   logic                  fwft_rd_en;
   logic                  rd_en;
   logic                  empty;
   logic [DATA_WIDTH-1:0] dout;
   logic                  valid;
   logic                  underflow;
   logic [CNT_W-1:0]      in_flight;

   modport slave (
      input  fwft_dout,
      input  fwft_empty,
      input  rd_en,
      output fwft_rd_en,
      output empty,
      output dout,
      output valid,
      output underflow,
      output in_flight
   );

   modport master (
      output fwft_dout,
      output fwft_empty,
      output rd_en,
      input  fwft_rd_en,
      input  empty,
      input  dout,
      input  valid,
      input  underflow,
      input  in_flight
   );

endinterface

// File: rtl/fwft_fifo_to_standard_fifo_pipe_delay.sv
// Fixed-depth shift register; every stage cleared by synchronous reset.
// No enable: all stages advance every cycle.
module pipe_delay #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= '0;
      end else begin
         r_q[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_q[i] <= r_q[i-1];
         end
      end
   end

   assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/fwft_fifo_to_standard_fifo.sv
// Converts an FWFT read port into a standard-FIFO read port whose data
// arrives a fixed READ_LATENCY cycles after rd_en.
module fwft_fifo_to_standard_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   fwft_fifo_to_standard_fifo_if.slave  bus
);

   localparam int CNT_W = cnt_width(READ_LATENCY);

   typedef struct packed {
      stage_flags_t          flags;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

   localparam int STAGE_W = $bits(stage_t);

   if (!lat_legal(READ_LATENCY)) begin : g_bad_latency
      $error("READ_LATENCY must be within 1..%0d", FIFO_READ_LATENCY_MAX);
   end

   logic                  w_accept;
   logic                  w_reject;
   logic                  w_fire;
   logic                  w_late_reject;
   stage_t                w_stage_in;
   stage_t                w_stage_out;
   logic [STAGE_W-1:0]    w_pipe_q;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [CNT_W-1:0]      r_in_flight;

   assign w_accept = bus.rd_en & ~bus.fwft_empty & ~rst;
   assign w_reject = bus.rd_en &  bus.fwft_empty & ~rst;

   always_comb begin
      w_stage_in              = '0;
      w_stage_in.flags.accept = w_accept;
      w_stage_in.flags.reject = w_reject;
      w_stage_in.data         = w_accept ? bus.fwft_dout : '0;
   end

   pipe_delay #(
      .WIDTH (STAGE_W),
      .DEPTH (READ_LATENCY)
   ) u_pipe (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (w_stage_in),
      .o_q   (w_pipe_q)
   );

   assign w_stage_out = w_pipe_q;

   // Words still in the line during reset are dropped, never presented.
   assign w_fire        = w_stage_out.flags.accept & ~rst;
   assign w_late_reject = w_stage_out.flags.reject & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout <= '0;
      end else if (w_fire) begin
         r_dout <= w_stage_out.data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_flight <= '0;
      end else begin
         unique case (1'b1)
            w_accept & ~w_fire: r_in_flight <= r_in_flight + CNT_W'(1);
            w_fire & ~w_accept: r_in_flight <= r_in_flight - CNT_W'(1);
            default:            r_in_flight <= r_in_flight;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      !(w_accept && !w_fire && r_in_flight == CNT_W'(READ_LATENCY)));

   assert property (@(posedge clk) disable iff (rst)
      !(w_fire && !w_accept && r_in_flight == '0));

   assign bus.fwft_rd_en = w_accept;
   assign bus.empty      = bus.fwft_empty;
   assign bus.valid      = w_fire;
   assign bus.underflow  = w_late_reject;
   assign bus.dout       = w_fire ? w_stage_out.data : r_dout;
   assign bus.in_flight  = r_in_flight;

endmodule
